// File: rtl/fp_round_unit_pkg.sv
// Shared types and constants for the single-precision rounding stage.
// Also holds the overflow-saturation helper used by the round FSM.
package fp_round_unit_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_t;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } round_mode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef enum logic {
        FU_FREE = 1'b0,
        FU_BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_RENORM = 2'd2,
        ST_VALID  = 2'd3
    } rnd_state_e;

    localparam float_t MAX_FINITE = 32'h7F7F_FFFF;
    localparam float_t P_INFTY    = 32'h7F80_0000;
    localparam float_t N_INFTY    = 32'hFF80_0000;
    localparam float_t CANO_NAN   = 32'h7FC0_0000;

    // Modes that round toward zero for this sign saturate at the largest finite value.
    function automatic float_t overflow_value(input logic sign, input logic [2:0] mode);
        float_t v;
        v = sign ? N_INFTY : P_INFTY;
        if ((mode == RTZ) || ((mode == RDN) && !sign) || ((mode == RUP) && sign)) begin
            v = {sign, MAX_FINITE[30:0]};
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_round_unit_decide.sv
// Combinational rounding decision: increment and inexact from sign, L, G, R, S and mode.
module fp_round_decide
    import fp_round_unit_pkg::*;
(
    input  logic        sign_i,
    input  logic        lsb_i,
    input  logic        guard_i,
    input  logic        round_i,
    input  logic        sticky_i,
    input  round_mode_e mode_i,
    output logic        inc_o,
    output logic        inexact_o
);

    always_comb begin
        inexact_o = guard_i | round_i | sticky_i;
        inc_o     = 1'b0;
        case (mode_i)
            RNE:     inc_o = guard_i & (round_i | sticky_i | lsb_i);
            RTZ:     inc_o = 1'b0;
            RDN:     inc_o = sign_i & inexact_o;
            RUP:     inc_o = ~sign_i & inexact_o;
            RMM:     inc_o = guard_i;
            default: inc_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_unit.sv
// Final rounding stage of the FP units: captures an unrounded result, applies the
// rounding mode, renormalises on mantissa carry and emits result plus fflags.
module fp_round_unit
    import fp_round_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        clk_en_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  float_t      operand_i,
    input  logic [2:0]  grs_i,
    input  round_mode_e round_mode_i,
    input  logic        invalid_op_i,
    input  logic        overflow_i,
    input  logic        underflow_i,
    output float_t      result_o,
    output fflags_t     fflags_o,
    output logic        valid_o,
    output fu_state_e   fu_state_o
);

    rnd_state_e state_q, state_d;
    float_t     op_q, op_d;
    logic [2:0] grs_q, grs_d;
    logic [2:0] rm_q, rm_d;
    logic       inv_q, inv_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    float_t     result_q, result_d;
    fflags_t    fflags_q, fflags_d;

    logic        round_inc;
    logic        inexact;
    logic [23:0] mant_sum;
    logic [7:0]  exp_inc;

    fp_round_decide u_decide (
        .sign_i    (op_q.sign),
        .lsb_i     (op_q.mantissa[0]),
        .guard_i   (grs_q[2]),
        .round_i   (grs_q[1]),
        .sticky_i  (grs_q[0]),
        .mode_i    (round_mode_e'(rm_q)),
        .inc_o     (round_inc),
        .inexact_o (inexact)
    );

    assign mant_sum = {1'b0, op_q.mantissa} + {23'd0, round_inc};
    assign exp_inc  = op_q.exponent + 8'd1;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        grs_d    = grs_q;
        rm_d     = rm_q;
        inv_d    = inv_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        result_d = result_q;
        fflags_d = fflags_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    op_d    = operand_i;
                    grs_d   = grs_i;
                    rm_d    = round_mode_i;
                    inv_d   = invalid_op_i;
                    ovf_d   = overflow_i;
                    unf_d   = underflow_i;
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                state_d = ST_VALID;
                if (inv_q || (rm_q > 3'd4)) begin
                    result_d    = CANO_NAN;
                    fflags_d    = '0;
                    fflags_d.nv = 1'b1;
                end else if (op_q.exponent == 8'hFF) begin
                    fflags_d = '0;
                    if (op_q.mantissa != 23'd0) begin
                        // Quiet NaNs are canonicalised silently; only signalling NaNs raise NV.
                        result_d    = CANO_NAN;
                        fflags_d.nv = ~op_q.mantissa[22];
                    end else begin
                        result_d = op_q;
                    end
                end else if (ovf_q) begin
                    result_d    = overflow_value(op_q.sign, rm_q);
                    fflags_d    = '0;
                    fflags_d.of = 1'b1;
                    fflags_d.nx = 1'b1;
                end else if (unf_q) begin
                    result_d    = {op_q.sign, 31'd0};
                    fflags_d    = '0;
                    fflags_d.uf = 1'b1;
                    fflags_d.nx = 1'b1;
                end else if (mant_sum[23]) begin
                    state_d = ST_RENORM;
                end else begin
                    result_d    = {op_q.sign, op_q.exponent, mant_sum[22:0]};
                    fflags_d    = '0;
                    fflags_d.nx = inexact;
                    fflags_d.uf = inexact & (op_q.exponent == 8'd0);
                end
            end

            ST_RENORM: begin
                state_d  = ST_VALID;
                fflags_d = '0;
                // A carry out of a denormal lands on exponent 1, a normal value, so no UF here.
                if (exp_inc == 8'hFF) begin
                    result_d    = overflow_value(op_q.sign, rm_q);
                    fflags_d.of = 1'b1;
                    fflags_d.nx = 1'b1;
                end else begin
                    result_d    = {op_q.sign, exp_inc, 23'd0};
                    fflags_d.nx = 1'b1;
                end
            end

            ST_VALID: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            grs_q    <= '0;
            rm_q     <= '0;
            inv_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            result_q <= '0;
            fflags_q <= '0;
        end else if (clk_en_i) begin
            state_q  <= state_d;
            op_q     <= op_d;
            grs_q    <= grs_d;
            rm_q     <= rm_d;
            inv_q    <= inv_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            result_q <= result_d;
            fflags_q <= fflags_d;
        end
    end

    assign result_o   = result_q;
    assign fflags_o   = fflags_q;
    assign valid_o    = (state_q == ST_VALID);
    assign fu_state_o = (state_q == ST_IDLE) ? FU_FREE : FU_BUSY;

endmodule

// File: tb/tb_fp_round_unit.sv
// Self-checking bench for fp_round_unit: directed vector table, control sequences
// and randomized operations against an arithmetic reference model.
module tb_fp_round_unit;
    import fp_round_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        clk_en_i;
    logic        rst_n_i;
    logic        valid_i;
    float_t      operand_i;
    logic [2:0]  grs_i;
    round_mode_e round_mode_i;
    logic        invalid_op_i;
    logic        overflow_i;
    logic        underflow_i;
    float_t      result_o;
    fflags_t     fflags_o;
    logic        valid_o;
    fu_state_e   fu_state_o;

    int total = 0;
    int bad   = 0;

    fp_round_unit dut (
        .clk_i        (clk_i),
        .clk_en_i     (clk_en_i),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid_i),
        .operand_i    (operand_i),
        .grs_i        (grs_i),
        .round_mode_i (round_mode_i),
        .invalid_op_i (invalid_op_i),
        .overflow_i   (overflow_i),
        .underflow_i  (underflow_i),
        .result_o     (result_o),
        .fflags_o     (fflags_o),
        .valid_o      (valid_o),
        .fu_state_o   (fu_state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] op;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic        inv;
        logic        ovf;
        logic        unf;
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] op, input logic [2:0] grs, input logic [2:0] rm,
                                input logic inv, input logic ovf, input logic unf,
                                input logic [31:0] res, input logic [4:0] flags, input int lat);
        vec_t v;
        v.op = op; v.grs = grs; v.rm = rm; v.inv = inv; v.ovf = ovf; v.unf = unf;
        v.res = res; v.flags = flags; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: treat G,R,S as eighths of an ulp and add the rounding step to the
    // whole exponent:mantissa magnitude, so carries into the exponent fall out naturally.
    task automatic model(input logic [31:0] op, input logic [2:0] grs, input logic [2:0] rm,
                         input logic inv, input logic ovf, input logic unf,
                         output logic [31:0] res, output logic [4:0] flags, output int lat);
        logic        sign;
        logic [7:0]  ex;
        logic [22:0] man;
        logic        up;
        logic        inexact;
        logic [30:0] mag;
        logic [31:0] ovf_val;
        sign = op[31];
        ex   = op[30:23];
        man  = op[22:0];
        lat   = 2;
        flags = 5'b00000;
        if ((rm == 3'd1) || ((rm == 3'd2) && !sign) || ((rm == 3'd3) && sign))
            ovf_val = {sign, 31'h7F7FFFFF};
        else
            ovf_val = {sign, 31'h7F800000};
        if (inv || rm > 3'd4) begin
            res = 32'h7FC00000; flags = 5'b10000;
        end else if (ex == 8'd255) begin
            if (man != 0) begin
                res = 32'h7FC00000;
                flags = man[22] ? 5'b00000 : 5'b10000;
            end else begin
                res = op;
            end
        end else if (ovf) begin
            res = ovf_val; flags = 5'b00101;
        end else if (unf) begin
            res = {sign, 31'd0}; flags = 5'b00011;
        end else begin
            inexact = (grs != 0);
            case (rm)
                3'd0:    up = (grs > 3'd4) || ((grs == 3'd4) && man[0]);
                3'd1:    up = 1'b0;
                3'd2:    up = sign && inexact;
                3'd3:    up = !sign && inexact;
                default: up = (grs >= 3'd4);
            endcase
            mag = op[30:0] + {30'd0, up};
            if (up && (man == 23'h7FFFFF)) lat = 3;
            if (mag[30:23] == 8'd255) begin
                res = ovf_val; flags = 5'b00101;
            end else begin
                res = {sign, mag};
                flags = {3'b000, inexact && (ex == 0) && (mag[30:23] == 0), inexact};
            end
        end
    endtask

    task automatic drive(input logic [31:0] op, input logic [2:0] grs, input logic [2:0] rm,
                         input logic inv, input logic ovf, input logic unf);
        operand_i    = op;
        grs_i        = grs;
        round_mode_i = round_mode_e'(rm);
        invalid_op_i = inv;
        overflow_i   = ovf;
        underflow_i  = unf;
        valid_i      = 1'b1;
    endtask

    // Issues one operation (call at a negedge with DUT idle) and checks result,
    // flags, latency, busy duration and the return to FREE.
    task automatic apply(input string name, input vec_t v);
        int          lat;
        int          busy;
        logic [31:0] res;
        logic [4:0]  fl;
        lat = -1; busy = 0; res = '0; fl = '0;
        drive(v.op, v.grs, v.rm, v.inv, v.ovf, v.unf);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            if (k == 1) valid_i = 1'b0;
            if (fu_state_o == FU_BUSY) busy++;
            if (valid_o) begin
                lat = k; res = result_o; fl = fflags_o;
                break;
            end
        end
        check({name, ".lat"}, lat, v.lat);
        check({name, ".res"}, res, v.res);
        check({name, ".flags"}, {27'd0, fl}, {27'd0, v.flags});
        check({name, ".busy"}, busy, v.lat);
        @(negedge clk_i);
        check({name, ".free"}, {31'd0, fu_state_o == FU_FREE && !valid_o}, 32'd1);
        $display("op %s: op=0x%08h grs=%03b rm=%0d -> res=0x%08h flags=%05b lat=%0d",
                 name, v.op, v.grs, v.rm, res, fl, lat);
    endtask

    vec_t vecs[17];

    initial begin
        int          vcnt;
        logic [31:0] op;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic        inv, ovf, unf;
        logic [31:0] er;
        logic [4:0]  ef;
        int          el;

        clk_en_i = 1'b1; rst_n_i = 1'b0; valid_i = 1'b0;
        operand_i = '0; grs_i = '0; round_mode_i = RNE;
        invalid_op_i = 1'b0; overflow_i = 1'b0; underflow_i = 1'b0;

        vecs[0]  = mk(32'h3F800001, 3'b100, 3'd0, 0, 0, 0, 32'h3F800002, 5'b00001, 2);
        vecs[1]  = mk(32'h3F800000, 3'b100, 3'd0, 0, 0, 0, 32'h3F800000, 5'b00001, 2);
        vecs[2]  = mk(32'h3FFFFFFF, 3'b110, 3'd0, 0, 0, 0, 32'h40000000, 5'b00001, 3);
        vecs[3]  = mk(32'h7F7FFFFF, 3'b100, 3'd0, 0, 0, 0, 32'h7F800000, 5'b00101, 3);
        vecs[4]  = mk(32'h7F7FFFFF, 3'b111, 3'd1, 0, 0, 0, 32'h7F7FFFFF, 5'b00001, 2);
        vecs[5]  = mk(32'hBF800000, 3'b001, 3'd2, 0, 0, 0, 32'hBF800001, 5'b00001, 2);
        vecs[6]  = mk(32'hBF800000, 3'b001, 3'd3, 0, 0, 0, 32'hBF800000, 5'b00001, 2);
        vecs[7]  = mk(32'h3F800000, 3'b000, 3'd0, 1, 0, 0, 32'h7FC00000, 5'b10000, 2);
        vecs[8]  = mk(32'h7F800001, 3'b000, 3'd0, 0, 0, 0, 32'h7FC00000, 5'b10000, 2);
        vecs[9]  = mk(32'h7FC00001, 3'b000, 3'd0, 0, 0, 0, 32'h7FC00000, 5'b00000, 2);
        vecs[10] = mk(32'h007FFFFF, 3'b100, 3'd0, 0, 0, 0, 32'h00800000, 5'b00001, 3);
        vecs[11] = mk(32'h00000001, 3'b010, 3'd0, 0, 0, 0, 32'h00000001, 5'b00011, 2);
        vecs[12] = mk(32'h7F000000, 3'b000, 3'd2, 0, 1, 0, 32'h7F7FFFFF, 5'b00101, 2);
        vecs[13] = mk(32'hBF000000, 3'b000, 3'd0, 0, 0, 1, 32'h80000000, 5'b00011, 2);
        vecs[14] = mk(32'h3F800000, 3'b000, 3'd5, 0, 0, 0, 32'h7FC00000, 5'b10000, 2);
        vecs[15] = mk(32'hFF800000, 3'b111, 3'd0, 0, 0, 0, 32'hFF800000, 5'b00000, 2);
        vecs[16] = mk(32'h3F800000, 3'b100, 3'd4, 0, 0, 0, 32'h3F800001, 5'b00001, 2);

        @(negedge clk_i); @(negedge clk_i);
        check("reset.result", result_o, 32'd0);
        check("reset.flags", {27'd0, fflags_o}, 32'd0);
        check("reset.valid", {31'd0, valid_o}, 32'd0);
        check("reset.state", {31'd0, fu_state_o == FU_BUSY}, 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 17; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while in ROUND: nothing comes out and the outputs clear.
        drive(32'h3F800001, 3'b100, 3'd0, 0, 0, 0);
        @(negedge clk_i);
        valid_i = 1'b0;
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        check("rst_mid.result", result_o, 32'd0);
        check("rst_mid.flags", {27'd0, fflags_o}, 32'd0);
        check("rst_mid.state", {31'd0, fu_state_o == FU_BUSY}, 32'd0);
        vcnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (valid_o) vcnt++;
            @(negedge clk_i);
        end
        check("rst_mid.no_valid", vcnt, 0);
        $display("seq reset_mid_round: valid_count=%0d", vcnt);

        // Clock enable held low while in VALID freezes the outputs.
        drive(32'hBF800000, 3'b001, 3'd2, 0, 0, 0);
        el = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            if (k == 1) valid_i = 1'b0;
            if (valid_o) begin el = k; break; end
        end
        check("clken.lat", el, 2);
        clk_en_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check($sformatf("clken.valid%0d", k), {31'd0, valid_o}, 32'd1);
            check($sformatf("clken.result%0d", k), result_o, 32'hBF800001);
        end
        clk_en_i = 1'b1;
        @(negedge clk_i);
        check("clken.release", {31'd0, valid_o}, 32'd0);
        $display("seq clk_en_hold: result=0x%08h", result_o);

        // valid_i while busy (sampled in ROUND and in VALID) is ignored.
        drive(32'h3F800001, 3'b100, 3'd0, 0, 0, 0);
        @(negedge clk_i);
        drive(32'h40000000, 3'b000, 3'd0, 0, 0, 0);
        vcnt = 0; er = 32'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            if (k == 1) valid_i = 1'b0;
            if (valid_o) begin vcnt++; er = result_o; end
        end
        check("busy_ignore.count", vcnt, 1);
        check("busy_ignore.result", er, 32'h3F800002);
        $display("seq busy_ignore: valid_count=%0d result=0x%08h", vcnt, er);

        for (int i = 0; i < 150; i++) begin
            vec_t v;
            op  = $urandom;
            case ($urandom_range(0, 9))
                0:       op[30:23] = 8'hFF;
                1:       begin op[30:23] = 8'hFE; op[22:0] = 23'h7FFFFF; end
                2:       begin op[30:23] = 8'h00; op[22:0] = 23'h7FFFFF; end
                3:       op[30:23] = 8'h00;
                default: if (op[30:23] == 8'hFF) op[30:23] = 8'h80;
            endcase
            grs = 3'($urandom_range(0, 7));
            rm  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            inv = ($urandom_range(0, 15) == 0);
            ovf = ($urandom_range(0, 15) == 0);
            unf = ($urandom_range(0, 15) == 0);
            model(op, grs, rm, inv, ovf, unf, er, ef, el);
            v = mk(op, grs, rm, inv, ovf, unf, er, ef, el);
            apply($sformatf("rnd%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_round_unit.md
Name: fp_round_unit

Overview:
- Final stage of every floating-point functional unit (add, mul, fused muladd, div, sqrt).
- Consumes the unrounded `float_t` result plus guard/round/sticky bits and upstream exception flags.
- Applies the RISC-V rounding mode, handles mantissa carry renormalisation and overflow saturation.
- Produces the architectural `float_t` result and the 5-bit fflags for the FP register file and fcsr.

Parameters:
- None. Single precision only; widths are fixed by `float_t`.

Ports:
- clk_i  input  1  clock
- clk_en_i  input  1  clock enable; all registers hold when low
- rst_n_i  input  1  reset, synchronous, active-low
- valid_i  input  1  upstream result valid, one-cycle pulse
- operand_i  input  32 (`float_t`)  unrounded result
- grs_i  input  3  guard, round, sticky bits; bit2 = G
- round_mode_i  input  3 (`round_mode_e`)  rounding mode, already resolved from DYN
- invalid_op_i  input  1  upstream invalid operation
- overflow_i  input  1  upstream overflow
- underflow_i  input  1  upstream underflow
- result_o  output  32 (`float_t`)  rounded result, registered
- fflags_o  output  5  {NV,DZ,OF,UF,NX}, bit4 = NV, registered
- valid_o  output  1  result/fflags valid, one cycle
- fu_state_o  output  1 (`fu_state_e`)  FREE when IDLE, else BUSY

Behaviour:
- Reset (rst_n_i low at posedge): state IDLE; result_o = 0; fflags_o = 0; valid_o = 0; all capture registers cleared.
- Reset mid-operation: any in-flight result is dropped, and no valid_o is produced for it.
- FSM: IDLE, ROUND, RENORM, VALID. It advances only when clk_en_i = 1.
- IDLE:
  - If valid_i = 1, capture operand_i, grs_i, round_mode_i and the three flags, then go to ROUND.
  - Otherwise stay in IDLE.
- valid_i outside IDLE is ignored. Upstream must watch fu_state_o.
- ROUND, special cases are checked in priority order:
  1. invalid_op_i, or round_mode = 101/110/111: result CANO_NAN (0x7FC00000), fflags NV. Go to VALID.
  2. Operand exponent = 255:
     - Mantissa != 0: result CANO_NAN. NV is set only when the mantissa MSB = 0 (sNaN).
     - Mantissa = 0 (infinity): pass through, no flags.
     - Go to VALID.
  3. overflow_i: OF|NX; result is the overflow value below. Go to VALID.
  4. underflow_i: UF|NX; result is signed zero. Go to VALID.
  5. Otherwise, normal rounding:
     - inexact = G|R|S.
     - Increment by mode, with L = mantissa LSB:
       - RNE: G&(R|S|L)
       - RTZ: 0
       - RDN: sign&inexact
       - RUP: ~sign&inexact
       - RMM: G
     - Form the 24-bit sum {0, mantissa} + increment.
     - If the sum carries out: latch it and go to RENORM.
     - Otherwise write the result, NX = inexact, UF = inexact & (exponent == 0), and go to VALID.
- RENORM:
  - Mantissa = 0, exponent + 1.
  - If the new exponent is 255: result is the overflow value, fflags OF|NX.
  - Otherwise NX set.
  - Go to VALID.
  - A denormal carrying into exponent 1 is a normal number: UF is not set.
- Overflow value:
  - ±infinity for RNE and RMM.
  - ±MAX_FINITE (0x7F7FFFFF magnitude) for RTZ, for RDN with a positive sign, and for RUP with a negative sign.
  - Infinity in the remaining cases.
- VALID: valid_o = 1 for exactly one cycle; next state IDLE.
- result_o and fflags_o are written on the entry edge into VALID and hold until the next entry into VALID.
- Latency, valid_i sampled at edge N:
  - valid_o high during cycle N+2 without renormalisation.
  - valid_o high during cycle N+3 with renormalisation.
- Throughput: one result per 3 or 4 cycles.
- clk_en_i low in any state: state, registers and outputs all frozen. valid_o stays high if frozen in VALID.
- DZ is never set here. It is ORed in by the divider path outside this block.

Decomposition:
- Shared package (Modules_pkg):
  - `round_mode_e` {RNE = 000, RTZ = 001, RDN = 010, RUP = 011, RMM = 100}
  - `fflags_t` packed struct {NV, DZ, OF, UF, NX}
  - constants MAX_FINITE, P_INFTY, N_INFTY, CANO_NAN
  - `float_t` and `fu_state_e` already exist there.
- One combinational sub-module, fp_round_decide: takes sign, L, G, R, S and the mode, and returns increment and inexact. The top level holds the FSM and datapath registers.

Test Plan:
- Round-to-nearest-even ties: 0x3F800001, grs = 100, RNE → 0x3F800002, fflags 00001. 0x3F800000, grs = 100, RNE → 0x3F800000, fflags 00001.
- Carry renormalisation: 0x3FFFFFFF, grs = 110, RNE → 0x40000000, NX. valid_o at N+3 and fu_state_o BUSY for 3 cycles.
- Overflow by mode: 0x7F7FFFFF, grs = 100, RNE → 0x7F800000, fflags 00101. The same operand with RTZ, grs = 111 → 0x7F7FFFFF, fflags 00001.
- Directed modes on a negative operand: 0xBF800000, grs = 001, RDN → 0xBF800001, NX. The same with RUP → 0xBF800000, NX.
- NaN and invalid operation: invalid_op_i = 1 → 0x7FC00000, fflags 10000. Operand 0x7F800001 → 0x7FC00000, fflags 10000. Operand 0x7FC00001 → 0x7FC00000, fflags 00000.
- Control:
  - rst_n_i low while in ROUND → IDLE next cycle, no valid_o, outputs 0.
  - clk_en_i low for 5 cycles in VALID → valid_o and result_o held.
  - valid_i pulsed while BUSY → ignored, with exactly one valid_o.
